// File: rtl/posit_batch_sequencer_if.sv
// rtl/posit_batch_sequencer_if.sv - memory-port and posit-unit handshake bundle for posit_batch_sequencer
interface posit_batch_sequencer_if #(
    parameter int ADDR_W = 12,
    parameter int WORD_W = 32
);
    logic [ADDR_W-1:0] m0_address;
    logic              m0_chipselect;
    logic              m0_clken;
    logic              m0_write;
    logic [7:0]        m0_writedata;
    logic [7:0]        m0_readdata;

    logic [ADDR_W-1:0] m1_address;
    logic              m1_chipselect;
    logic              m1_clken;
    logic              m1_write;
    logic [7:0]        m1_writedata;
    logic [7:0]        m1_readdata;

    logic              op_valid;
    logic              op_ready;
    logic [WORD_W-1:0] op_a;
    logic [WORD_W-1:0] op_b;
    logic              res_valid;
    logic [WORD_W-1:0] res_data;

    modport master (
        output m0_address, m0_chipselect, m0_clken, m0_write, m0_writedata,
        input  m0_readdata,
        output m1_address, m1_chipselect, m1_clken, m1_write, m1_writedata,
        input  m1_readdata,
        output op_valid, op_a, op_b,
        input  op_ready, res_valid, res_data
    );

    modport slave (
        input  m0_address, m0_chipselect, m0_clken, m0_write, m0_writedata,
        output m0_readdata,
        input  m1_address, m1_chipselect, m1_clken, m1_write, m1_writedata,
        output m1_readdata,
        input  op_valid, op_a, op_b,
        output op_ready, res_valid, res_data
    );
endinterface

// File: rtl/posit_batch_sequencer.sv
// rtl/posit_batch_sequencer.sv - streams operand pairs to a posit unit and stores results to memory
// Optional cycle counter output enabled by POSIT_SEQ_CYCLE_COUNT_EN.
module posit_batch_sequencer #(
    parameter int ADDR_W     = 12,
    parameter int WORD_W     = 32,
    parameter int MEM_RD_LAT = 1,
    parameter int CNT_W      = 10
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] num_ops,
    output logic             busy,
    output logic             completed,
`ifdef POSIT_SEQ_CYCLE_COUNT_EN
    output logic [31:0]      cycle_count,
`endif
    posit_batch_sequencer_if.master bus
);
    localparam int B       = WORD_W / 8;
    localparam int NB      = 2 * B;
    localparam int MAX_OPS = (1 << ADDR_W) / NB;
    localparam int CW      = $clog2(MAX_OPS + 1);
    localparam int BCW     = $clog2(NB + 1);

    localparam logic [BCW-1:0] NB_L        = BCW'(NB);
    localparam logic [BCW-1:0] LAST_BYTE_L = BCW'(NB - 1);
    localparam logic [BCW-1:0] LAST_ST_L   = BCW'(B - 1);
    localparam logic [CW-1:0]  MAX_L       = CW'(MAX_OPS);

    typedef enum logic [2:0] {
        S_IDLE, S_FETCH, S_ISSUE, S_WAIT, S_STORE, S_DONE
    } state_t;

    state_t                  state_q, state_d;
    logic [CW-1:0]           count_q, count_d;
    logic [CW-1:0]           idx_q, idx_d;
    logic [BCW-1:0]          rd_cnt_q, rd_cnt_d;
    logic [BCW-1:0]          cap_cnt_q, cap_cnt_d;
    logic [BCW-1:0]          st_cnt_q, st_cnt_d;
    logic [ADDR_W-1:0]       rd_addr_q, rd_addr_d;
    logic [ADDR_W-1:0]       wr_addr_q, wr_addr_d;
    logic [MEM_RD_LAT-1:0]   vld_q, vld_d;
    logic [2*WORD_W-1:0]     pair_q, pair_d;
    logic [WORD_W-1:0]       res_q, res_d;
    logic                    busy_q, busy_d;
    logic                    completed_q, completed_d;

    logic                    issue;
    logic                    capture;
    logic [31:0]             req32;
    logic [CW-1:0]           sat_cnt;
    logic                    accept;
    logic                    unused_rd;

    assign unused_rd = ^bus.m1_readdata;

    assign issue   = (state_q == S_FETCH) && (rd_cnt_q < NB_L);
    assign capture = vld_q[MEM_RD_LAT-1];
    assign accept  = (state_q == S_IDLE) && start;
    assign req32   = 32'(num_ops);
    assign sat_cnt = (req32 > 32'(MAX_OPS)) ? MAX_L : CW'(req32);

    always_comb begin
        state_d     = state_q;
        count_d     = count_q;
        idx_d       = idx_q;
        rd_cnt_d    = rd_cnt_q;
        cap_cnt_d   = cap_cnt_q;
        st_cnt_d    = st_cnt_q;
        rd_addr_d   = rd_addr_q;
        wr_addr_d   = wr_addr_q;
        pair_d      = pair_q;
        res_d       = res_q;
        busy_d      = busy_q;
        completed_d = completed_q;

        // Read-valid tags travel alongside the memory latency so capture needs no address compare.
        vld_d    = '0;
        vld_d[0] = issue;
        for (int i = 1; i < MEM_RD_LAT; i++) vld_d[i] = vld_q[i-1];

        if (issue) begin
            rd_cnt_d  = rd_cnt_q + BCW'(1);
            rd_addr_d = rd_addr_q + ADDR_W'(1);
        end
        if (capture) begin
            pair_d    = {bus.m0_readdata, pair_q[2*WORD_W-1:8]};
            cap_cnt_d = cap_cnt_q + BCW'(1);
        end

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    completed_d = 1'b0;
                    busy_d      = 1'b1;
                    count_d     = sat_cnt;
                    idx_d       = '0;
                    rd_cnt_d    = '0;
                    cap_cnt_d   = '0;
                    rd_addr_d   = '0;
                    wr_addr_d   = '0;
                    state_d     = (sat_cnt == '0) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                if (capture && (cap_cnt_q == LAST_BYTE_L)) state_d = S_ISSUE;
            end
            S_ISSUE: begin
                if (bus.op_ready) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.res_valid) begin
                    res_d    = bus.res_data;
                    st_cnt_d = '0;
                    state_d  = S_STORE;
                end
            end
            S_STORE: begin
                res_d     = res_q >> 8;
                st_cnt_d  = st_cnt_q + BCW'(1);
                wr_addr_d = wr_addr_q + ADDR_W'(1);
                if (st_cnt_q == LAST_ST_L) begin
                    if (idx_q + CW'(1) == count_q) begin
                        state_d = S_DONE;
                    end else begin
                        idx_d     = idx_q + CW'(1);
                        rd_cnt_d  = '0;
                        cap_cnt_d = '0;
                        state_d   = S_FETCH;
                    end
                end
            end
            S_DONE: begin
                busy_d      = 1'b0;
                completed_d = 1'b1;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            count_q     <= '0;
            idx_q       <= '0;
            rd_cnt_q    <= '0;
            cap_cnt_q   <= '0;
            st_cnt_q    <= '0;
            rd_addr_q   <= '0;
            wr_addr_q   <= '0;
            vld_q       <= '0;
            pair_q      <= '0;
            res_q       <= '0;
            busy_q      <= 1'b0;
            completed_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            idx_q       <= idx_d;
            rd_cnt_q    <= rd_cnt_d;
            cap_cnt_q   <= cap_cnt_d;
            st_cnt_q    <= st_cnt_d;
            rd_addr_q   <= rd_addr_d;
            wr_addr_q   <= wr_addr_d;
            vld_q       <= vld_d;
            pair_q      <= pair_d;
            res_q       <= res_d;
            busy_q      <= busy_d;
            completed_q <= completed_d;
        end
    end

`ifdef POSIT_SEQ_CYCLE_COUNT_EN
    logic [31:0] cyc_q, cyc_d;

    always_comb begin
        cyc_d = cyc_q;
        if (accept) begin
            cyc_d = '0;
        end else if (busy_q && (cyc_q != 32'hFFFF_FFFF)) begin
            cyc_d = cyc_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) cyc_q <= '0;
        else       cyc_q <= cyc_d;
    end

    assign cycle_count = cyc_q;
`else
    logic unused_accept;
    assign unused_accept = accept;
`endif

    assign busy      = busy_q;
    assign completed = completed_q;

    assign bus.op_valid = (state_q == S_ISSUE);
    assign bus.op_a     = pair_q[WORD_W-1:0];
    assign bus.op_b     = pair_q[2*WORD_W-1:WORD_W];

    assign bus.m0_chipselect = issue;
    assign bus.m0_clken      = issue;
    assign bus.m0_address    = issue ? rd_addr_q : '0;
    assign bus.m0_write      = 1'b0;
    assign bus.m0_writedata  = 8'h00;

    assign bus.m1_write      = (state_q == S_STORE);
    assign bus.m1_chipselect = (state_q == S_STORE);
    assign bus.m1_clken      = (state_q == S_STORE);
    assign bus.m1_address    = (state_q == S_STORE) ? wr_addr_q : '0;
    assign bus.m1_writedata  = (state_q == S_STORE) ? res_q[7:0] : 8'h00;
endmodule

// File: tb/tb_posit_batch_sequencer.sv
// tb/tb_posit_batch_sequencer.sv - self-checking bench for posit_batch_sequencer
module tb_posit_batch_sequencer;
    localparam int ADDR_W = 12;
    localparam int WORD_W = 32;
    localparam int LAT    = 1;
    localparam int CNT_W  = 10;
    localparam int B      = WORD_W / 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic [CNT_W-1:0] num_ops;
    logic             busy;
    logic             completed;
`ifdef POSIT_SEQ_CYCLE_COUNT_EN
    logic [31:0]      cycle_count;
`endif

    always #5 clk = ~clk;

    posit_batch_sequencer_if #(.ADDR_W(ADDR_W), .WORD_W(WORD_W)) bus ();

    posit_batch_sequencer #(
        .ADDR_W(ADDR_W), .WORD_W(WORD_W), .MEM_RD_LAT(LAT), .CNT_W(CNT_W)
    ) dut (
        .clock(clk),
        .reset(reset),
        .start(start),
        .num_ops(num_ops),
        .busy(busy),
        .completed(completed),
`ifdef POSIT_SEQ_CYCLE_COUNT_EN
        .cycle_count(cycle_count),
`endif
        .bus(bus.master)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    typedef struct packed { logic [ADDR_W-1:0] addr; logic [7:0] data; } wr_t;
    typedef struct packed { logic [WORD_W-1:0] a; logic [WORD_W-1:0] b; } op_t;
    typedef struct { int n; int mode; int stall; int ulat; int exp_pairs; bit mid; } vec_t;

    logic [7:0] m0_mem [1 << ADDR_W];
    logic [7:0] m1_mem [1 << ADDR_W];
    wr_t        exp_wr_q [$];
    op_t        exp_op_q [$];

    int mode, stall_cfg, ulat, stall_left, cd, valid_run;
    int m0_reads, m1_writes, handshakes, busy_cycles, max_m1;
    int cyc, start_cyc, first_read_cyc;
    logic [7:0]        rd_pipe;
    logic [WORD_W-1:0] pend_res;

    // Negedge-driven models: operand memory, result memory, posit unit and scoreboard.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (busy === 1'b1) busy_cycles++;
            if (start === 1'b1 && busy === 1'b0) start_cyc = cyc;

            bus.m0_readdata = rd_pipe;
            rd_pipe = 8'h00;
            if (bus.m0_chipselect === 1'b1 && bus.m0_clken === 1'b1) begin
                m0_reads++;
                if (first_read_cyc < 0) first_read_cyc = cyc;
                rd_pipe = m0_mem[bus.m0_address];
            end

            if (bus.m1_write === 1'b1 && bus.m1_chipselect === 1'b1 && bus.m1_clken === 1'b1) begin
                wr_t e;
                m1_writes++;
                m1_mem[bus.m1_address] = bus.m1_writedata;
                if (int'(bus.m1_address) > max_m1) max_m1 = int'(bus.m1_address);
                if (exp_wr_q.size() == 0) begin
                    check("m1_unexpected_write", 64'(bus.m1_address), 64'hFFFF);
                end else begin
                    e = exp_wr_q.pop_front();
                    check("m1_addr", 64'(bus.m1_address), 64'(e.addr));
                    check("m1_data", 64'(bus.m1_writedata), 64'(e.data));
                end
            end

            bus.res_valid = 1'b0;
            bus.res_data  = 32'hDEAD_BEEF;
            if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    bus.res_valid = 1'b1;
                    bus.res_data  = pend_res;
                end
            end

            if (bus.op_valid === 1'b1) begin
                valid_run++;
                if (stall_left > 0) begin
                    bus.op_ready = 1'b0;
                    stall_left--;
                    if (exp_op_q.size() > 0) begin
                        check("stall_op_a", 64'(bus.op_a), 64'(exp_op_q[0].a));
                        check("stall_op_b", 64'(bus.op_b), 64'(exp_op_q[0].b));
                    end
                end else begin
                    bus.op_ready = 1'b1;
                end
            end else begin
                valid_run    = 0;
                bus.op_ready = 1'b0;
            end

            if (bus.op_valid === 1'b1 && bus.op_ready === 1'b1) begin
                op_t e;
                handshakes++;
                check("valid_cycles_before_handshake", 64'(valid_run), 64'(stall_cfg + 1));
                if (exp_op_q.size() == 0) begin
                    check("unexpected_handshake", 64'(handshakes), 64'hFFFF);
                end else begin
                    e = exp_op_q.pop_front();
                    check("op_a", 64'(bus.op_a), 64'(e.a));
                    check("op_b", 64'(bus.op_b), 64'(e.b));
                    pend_res = (mode == 0) ? 32'h4800_0000 : (e.a ^ e.b);
                end
                cd         = ulat;
                stall_left = stall_cfg;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_busy"}, 64'(busy), 64'd0);
        check({tag, "_completed"}, 64'(completed), 64'd0);
        check({tag, "_op"}, {31'd0, bus.op_valid, bus.op_a}, 64'd0);
        check({tag, "_op_b"}, 64'(bus.op_b), 64'd0);
        check({tag, "_m0"}, {bus.m0_address, bus.m0_chipselect, bus.m0_clken, bus.m0_write, bus.m0_writedata}, 64'd0);
        check({tag, "_m1"}, {bus.m1_address, bus.m1_chipselect, bus.m1_clken, bus.m1_write, bus.m1_writedata}, 64'd0);
`ifdef POSIT_SEQ_CYCLE_COUNT_EN
        check({tag, "_cycle_count"}, 64'(cycle_count), 64'd0);
`endif
    endtask

    task automatic prep(input int n, input int md, input int stall, input int ul, input int exp_pairs);
        logic [WORD_W-1:0] a, b, r;
        mode = md; stall_cfg = stall; ulat = ul; stall_left = stall; cd = 0;
        exp_wr_q.delete();
        exp_op_q.delete();
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            m0_mem[i] = 8'($urandom);
            m1_mem[i] = 8'hEE;
        end
        if (md == 0) begin
            for (int i = 0; i < 8; i++) m0_mem[i] = (i % 4 == 3) ? 8'h40 : 8'h00;
        end
        for (int i = 0; i < exp_pairs; i++) begin
            for (int k = 0; k < B; k++) begin
                a[8*k +: 8] = m0_mem[2*B*i + k];
                b[8*k +: 8] = m0_mem[2*B*i + B + k];
            end
            r = (md == 0) ? 32'h4800_0000 : (a ^ b);
            exp_op_q.push_back('{a: a, b: b});
            for (int k = 0; k < B; k++) exp_wr_q.push_back('{addr: ADDR_W'(B*i + k), data: r[8*k +: 8]});
        end
        m0_reads = 0; m1_writes = 0; handshakes = 0; busy_cycles = 0;
        max_m1 = -1; start_cyc = -1; first_read_cyc = -1; n = n;
    endtask

    task automatic run_batch(input vec_t v);
        int  t;
        bit  done;
        int  exp_busy;
        prep(v.n, v.mode, v.stall, v.ulat, v.exp_pairs);
        num_ops = CNT_W'(v.n);
        start   = 1'b1;
        tick();
        start   = 1'b0;
        done    = 1'b0;
        for (t = 0; t < 20000 && !done; t++) begin
            tick();
            start = (v.mid && t == 20) ? 1'b1 : 1'b0;
            if (v.mid && t == 20) num_ops = CNT_W'(7);
            if (completed === 1'b1) done = 1'b1;
        end
        start = 1'b0;
        check("batch_timeout", 64'(done), 64'd1);
        tick();
        exp_busy = (v.exp_pairs == 0) ? 1
                 : v.exp_pairs * ((2*B + LAT) + (1 + v.stall) + v.ulat + B) + 1;
        check("completed", 64'(completed), 64'd1);
        check("busy_after_done", 64'(busy), 64'd0);
        check("handshakes", 64'(handshakes), 64'(v.exp_pairs));
        check("m0_reads", 64'(m0_reads), 64'(2*B*v.exp_pairs));
        check("m1_writes", 64'(m1_writes), 64'(B*v.exp_pairs));
        check("max_m1_addr", 64'(max_m1), 64'(B*v.exp_pairs - 1));
        check("pending_writes", 64'(exp_wr_q.size()), 64'd0);
        check("busy_cycles", 64'(busy_cycles), 64'(exp_busy));
        if (v.exp_pairs > 0) check("start_to_first_read", 64'(first_read_cyc - start_cyc), 64'd1);
`ifdef POSIT_SEQ_CYCLE_COUNT_EN
        check("cycle_count", 64'(cycle_count), 64'(exp_busy));
`endif
    endtask

    vec_t vecs[5];

    initial begin
        int t;
        int snap;
        bit hit;
        reset = 1'b1; start = 1'b0; num_ops = '0;
        bus.m0_readdata = 8'h00; bus.m1_readdata = 8'h00;
        bus.op_ready = 1'b0; bus.res_valid = 1'b0; bus.res_data = '0;
        rd_pipe = 8'h00; cyc = 0; cd = 0; stall_left = 0; stall_cfg = 0; valid_run = 0;
        ulat = 1; mode = 1;

        vecs[0] = '{n: 1,   mode: 0, stall: 0,  ulat: 3, exp_pairs: 1,   mid: 1'b0};
        vecs[1] = '{n: 0,   mode: 1, stall: 0,  ulat: 1, exp_pairs: 0,   mid: 1'b0};
        vecs[2] = '{n: 2,   mode: 1, stall: 10, ulat: 1, exp_pairs: 2,   mid: 1'b0};
        vecs[3] = '{n: 3,   mode: 1, stall: 0,  ulat: 2, exp_pairs: 3,   mid: 1'b1};
        vecs[4] = '{n: 600, mode: 1, stall: 0,  ulat: 1, exp_pairs: 512, mid: 1'b0};

        repeat (3) tick();
        check_reset_outputs("reset");
        reset = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            run_batch(vecs[i]);
            if (i == 0) begin
                check("single_m1_bytes", {m1_mem[3], m1_mem[2], m1_mem[1], m1_mem[0]}, 64'h4800_0000);
            end
            repeat (2) tick();
        end

        // Abort during the second pair's store, then confirm a clean restart.
        prep(3, 1, 0, 1, 3);
        num_ops = CNT_W'(3);
        start   = 1'b1;
        tick();
        start   = 1'b0;
        hit     = 1'b0;
        for (t = 0; t < 500 && !hit; t++) begin
            tick();
            if (bus.m1_write === 1'b1 && bus.m1_address == ADDR_W'(B + 1)) hit = 1'b1;
        end
        check("abort_reached_store", 64'(hit), 64'd1);
        reset = 1'b1;
        tick();
        check_reset_outputs("abort");
        snap = m1_writes;
        repeat (4) tick();
        check("abort_no_writes", 64'(m1_writes), 64'(snap));
        reset = 1'b0;
        tick();
        run_batch('{n: 1, mode: 1, stall: 0, ulat: 1, exp_pairs: 1, mid: 1'b0});
        check("restart_m1_bytes", {m1_mem[3], m1_mem[2], m1_mem[1], m1_mem[0]},
              64'({m0_mem[3], m0_mem[2], m0_mem[1], m0_mem[0]} ^ {m0_mem[7], m0_mem[6], m0_mem[5], m0_mem[4]}));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
